prod_reg_reader: RTL
====================

# prod_reg_reader

Serial-to-parallel reader for the product-gate two-word registers: the ID (PI), MQ (PR) and PN (PP) drum-track outputs. On a host request it waits for the start of the even word and deserialises the selected recirculating track into a parallel word. The word is presented on a valid/ready port to the debug/front-panel host. It only observes the tracks and never drives the early bus or any register input.

## Interface
Parameters:
- WORDS, 2: number of 29-bit words captured (1 = even word only, 2 = even+odd).
- NBITS, 29*WORDS: derived capture width; not overridden independently.
- SYNC_TIMEOUT, 127: maximum clocks spent waiting for an even-word T1 before the request is aborted with an error.

Ports:
- CLOCK  in  1  system clock; one drum bit time per cycle.
- rst  in  1  reset; asynchronous, active-high.
- T1  in  1  first bit time of a word.
- T29  in  1  last bit time of a word.
- ODD  in  1  high throughout the odd word of the register pair.
- PI, PR, PP  in  1 each  ID, MQ and PN track serial outputs.
- rd_req  in  1  capture request; sampled in IDLE only.
- rd_sel  in  2  track select, latched on accept: 00 ID, 01 MQ, 10 PN, 11 illegal.
- rd_busy  out  1  high in SYNC and CAPTURE.
- rd_valid  out  1  captured word available.
- rd_ready  in  1  host accepts the word.
- rd_data  out  NBITS  captured word; bit 0 is the bit at even-word T1.
- rd_err  out  1  sticky error flag; cleared on the next accepted request.

## Operation
States and transitions:
- IDLE → SYNC when rd_req=1. rd_sel is latched, rd_err is cleared and the timeout counter is zeroed.
- IDLE with rd_req=1 and rd_sel=11: rd_err sets and the state stays IDLE.
- SYNC: the timeout counter increments every cycle.
- SYNC → CAPTURE in the first cycle with T1=1 and ODD=0. That cycle's selected bit is stored as rd_data[0] and the bit index becomes 1.
- SYNC → IDLE with rd_err=1 when the timeout counter reaches SYNC_TIMEOUT.
- CAPTURE: each cycle the selected bit is stored at rd_data[index] and the index increments. The 6-bit index covers 0..57.
- Framing check during CAPTURE, performed before the bit is stored:
  - index 0 and 29 must coincide with T1; index 28 and 57 must coincide with T29.
  - ODD must be 0 for indices 0..28 and 1 for indices 29..57.
  - Any mismatch: rd_err=1, state goes to IDLE, and rd_data is left partial with rd_valid=0.
- CAPTURE → HOLD after index NBITS-1 is stored (T29 of the last word).
- HOLD: rd_valid=1 and rd_data is stable. On a clock edge with rd_ready=1, the state goes to IDLE and rd_valid=0 next cycle.
- rd_req is ignored outside IDLE.
- rd_ready is ignored outside HOLD.

## Timing
Reset values (asynchronous, immediate on rst):
- state IDLE, rd_busy=0, rd_valid=0, rd_err=0, rd_data=0, all counters 0.
- Reset asserted mid-SYNC or mid-CAPTURE abandons the capture without flagging rd_err.

Latency:
- rd_busy rises the cycle after the accepting edge.
- The sync cycle is the first cycle in SYNC with T1 & ~ODD. A request accepted at edge k is therefore not sampled against a T1 occurring in cycle k; that T1 is missed.
- rd_valid rises the cycle after the final bit: sync cycle + NBITS (58 for WORDS=2, 29 for WORDS=1).
- rd_busy falls in the same cycle rd_valid rises.

Other rules:
- In SYNC, the counter value SYNC_TIMEOUT is checked before the T1 test. If both occur in the same cycle, the timeout wins.
- rd_valid and rd_ready both 1 at an edge: transfer. A new rd_req is accepted no earlier than the following edge, from IDLE.
- rd_data holds its last value after the transfer and is overwritten bit-by-bit during the next capture.

## Test plan
- MQ single bit: rd_sel=01; PR=1 only at even-word T1. Expect rd_data=58'h1, rd_valid after sync+58 cycles, rd_err=0.
- PN all ones: rd_sel=10; PP=1 throughout. Expect rd_data=58'h3FFFFFFFFFFFFFF. Hold rd_ready=0 for 10 cycles: rd_valid and rd_data must stay stable. Pulse rd_ready: rd_valid=0 next cycle.
- ID odd-word MSB: rd_sel=00; PI=1 only at odd-word T29. Expect rd_data=58'h200000000000000. With WORDS=1, the same stimulus gives rd_data=29'h0 and rd_valid after 29 cycles.
- Framing error: force T29 one cycle early in the odd word. Expect rd_err=1, rd_valid=0, state IDLE. The next valid request clears rd_err.
- Timeout and illegal select:
  - Hold T1=0 after a request: rd_err=1 after 127 SYNC cycles.
  - rd_sel=11: rd_err=1, rd_busy never rises.
- Reset mid-capture: assert rst at bit index 20. Expect immediate rd_busy=0, rd_data=0, rd_err=0. A new request then captures a correct word.

Source files
------------

// File: rtl/prod_reg_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// prod_reg_reader
//
// Serial-to-parallel reader for the product-gate two-word registers (ID, MQ,
// PN drum tracks). On a host request it waits for the start of an even word,
// deserialises the selected recirculating track into a parallel word, then
// presents it on a valid/ready port. The block only observes the tracks.
//
// Parameters:
//   WORDS        - 29-bit words captured (1 = even only, 2 = even + odd)
//   NBITS        - capture width, derived from WORDS
//   SYNC_TIMEOUT - clocks to wait for an even-word T1 before aborting
//
// Ports:
//   CLOCK        - system clock, one drum bit time per cycle
//   rst          - asynchronous active-high reset
//   T1, T29      - first / last bit time of a word
//   ODD          - high throughout the odd word of the pair
//   PI, PR, PP   - ID, MQ, PN track serial outputs
//   rd_req       - capture request (sampled in IDLE only)
//   rd_sel       - track select: 00 ID, 01 MQ, 10 PN, 11 illegal
//   rd_busy      - high while waiting for sync or capturing
//   rd_valid     - captured word available
//   rd_ready     - host accepts the word
//   rd_data      - captured word, bit 0 = bit at even-word T1
//   rd_err       - sticky error (illegal select, timeout, framing)
// -----------------------------------------------------------------------------
module prod_reg_reader #(
    parameter int WORDS        = 2,
    parameter int NBITS        = 29 * WORDS,
    parameter int SYNC_TIMEOUT = 127
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic             T1,
    input  logic             T29,
    input  logic             ODD,
    input  logic             PI,
    input  logic             PR,
    input  logic             PP,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    output logic             rd_busy,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [NBITS-1:0] rd_data,
    output logic             rd_err
);

    localparam int CW = (SYNC_TIMEOUT < 2) ? 1 : $clog2(SYNC_TIMEOUT + 1);

    localparam logic [CW-1:0] TMO_VAL  = CW'(SYNC_TIMEOUT);
    localparam logic [5:0]    LAST_IDX = 6'(NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_CAP,
        S_HOLD
    } state_t;

    state_t          state, state_n;
    logic [1:0]      sel_q, sel_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [5:0]      idx_q, idx_n;
    logic            err_n;
    logic            bit_we;
    logic [5:0]      wr_idx;
    logic            trk_bit;
    logic            frame_ok;

    // Selected track bit for this bit time.
    always_comb begin
        trk_bit = 1'b0;
        case (sel_q)
            2'b00:   trk_bit = PI;
            2'b01:   trk_bit = PR;
            2'b10:   trk_bit = PP;
            default: trk_bit = 1'b0;
        endcase
    end

    // Drum framing expected at the current capture index: word boundaries
    // must line up with T1/T29 and the ODD level must match the word half.
    always_comb begin
        frame_ok = 1'b1;
        if ((idx_q == 6'd0 || idx_q == 6'd29) && !T1)
            frame_ok = 1'b0;
        if ((idx_q == 6'd28 || idx_q == 6'd57) && !T29)
            frame_ok = 1'b0;
        if (ODD != (idx_q >= 6'd29))
            frame_ok = 1'b0;
    end

    // Next-state and control.
    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        err_n   = rd_err;
        bit_we  = 1'b0;
        wr_idx  = idx_q;

        case (state)
            S_IDLE: begin
                if (rd_req) begin
                    if (rd_sel == 2'b11) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = S_SYNC;
                        sel_n   = rd_sel;
                        err_n   = 1'b0;
                        cnt_n   = '0;
                        idx_n   = 6'd0;
                    end
                end
            end

            S_SYNC: begin
                // Timeout takes priority over a T1 seen in the same cycle.
                if (cnt_q == TMO_VAL) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                    if (T1 && !ODD) begin
                        bit_we  = 1'b1;
                        wr_idx  = 6'd0;
                        idx_n   = 6'd1;
                        state_n = S_CAP;
                    end
                end
            end

            S_CAP: begin
                // A framing slip aborts with the partial word left in place.
                if (!frame_ok) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end else begin
                    bit_we = 1'b1;
                    idx_n  = idx_q + 6'd1;
                    if (idx_q == LAST_IDX)
                        state_n = S_HOLD;
                end
            end

            S_HOLD: begin
                if (rd_ready)
                    state_n = S_IDLE;
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sel_q  <= 2'b00;
            cnt_q  <= '0;
            idx_q  <= 6'd0;
            rd_err <= 1'b0;
        end else begin
            state  <= state_n;
            sel_q  <= sel_n;
            cnt_q  <= cnt_n;
            idx_q  <= idx_n;
            rd_err <= err_n;
        end
    end

    // Bit-addressed write: untouched bits keep their previous capture.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (bit_we) begin
            for (int i = 0; i < NBITS; i++) begin
                if (wr_idx == 6'(i))
                    rd_data[i] <= trk_bit;
            end
        end
    end

    assign rd_busy  = (state == S_SYNC) || (state == S_CAP);
    assign rd_valid = (state == S_HOLD);

endmodule
